// File: rtl/spi_reg_bank.sv
// spi_reg_bank -- SPI-slave (mode 1) register bank, clocked entirely from clk.
//
// SCLK, CS and MOSI are oversampled through 2-flop synchronisers. SCLK and CS
// get a third flop for edge detection. A frame is an address byte
// (bit 7 = write flag, bits 6:0 = address) followed by a DW-bit data word,
// MSB first. The frame either writes one of NREG registers or reads it back
// on MISO.
//
// Optional feature: define SPI_REG_READBACK_EN to build the MISO readback
// shifter. Without it, miso is tied to 0 and reads return zeros.
//
// Parameters:
//   DW        data word width (>= 2)
//   NREG      number of registers (1..128)
//   RESET_VAL reset value of every register
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   sclk      SPI clock (asynchronous)
//   cs        SPI chip select, active low (asynchronous)
//   mosi      SPI data in (asynchronous)
//   miso      SPI data out
//   regs      flat register contents, register 0 in [DW-1:0]
//   wr_stb    one-cycle pulse when a register is committed
//   wr_addr   address of the last committed write
//   frame_err one-cycle pulse on a malformed frame
module spi_reg_bank #(
  parameter int              DW        = 8,
  parameter int              NREG      = 4,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  output logic [NREG*DW-1:0]   regs,
  output logic                 wr_stb,
  output logic [6:0]           wr_addr,
  output logic                 frame_err
);

  localparam int CW = $clog2(8 + DW + 2);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(7);
  localparam logic [CW-1:0] CNT_FULL      = CW'(8 + DW);
  localparam logic [CW-1:0] CNT_MAX       = CW'(8 + DW + 1);
  localparam logic [7:0]    NREG_L        = 8'(NREG);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sclk_q;
  logic [2:0]      cs_q;
  logic [1:0]      mosi_q;
  logic [CW-1:0]   bit_cnt;
  logic [6:0]      addr_sh;
  logic [DW-1:0]   data_sh;
  logic            wr_flag;
  logic [6:0]      addr_q;
  logic [DW-1:0]   reg_q [NREG];
  logic            commit_wr;
  logic            commit_err;

  // Synchronised view of the pins. CS resets high so that releasing reset
  // with the bus idle produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sclk_fall, cs_rise, cs_low, mosi_bit, addr_last_fall, frame_full, addr_ok;
  assign sclk_fall      = sclk_q[2] & ~sclk_q[1];
  assign cs_rise        = ~cs_q[2] & cs_q[1];
  assign cs_low         = ~cs_q[1];
  assign mosi_bit       = mosi_q[1];
  assign addr_last_fall = (state_q == ADDR) && sclk_fall && cs_low && (bit_cnt == CNT_ADDR_LAST);
  assign frame_full     = (bit_cnt == CNT_FULL);
  assign addr_ok        = ({1'b0, addr_q} < NREG_L);

  // The counter clears from the third CS flop, one cycle after the FSM sees
  // the rising edge, so COMMIT still sees the count of the frame just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (cs_q[2]) begin
      bit_cnt <= '0;
    end else if (sclk_fall && cs_low && (bit_cnt != CNT_MAX)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Address and data shifters. The address byte is only latched on its 8th
  // bit; the data shifter simply keeps the last DW bits seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sh <= '0;
      data_sh <= '0;
      wr_flag <= 1'b0;
      addr_q  <= '0;
    end else begin
      if ((state_q == ADDR) && sclk_fall && cs_low)
        addr_sh <= {addr_sh[5:0], mosi_bit};
      if (addr_last_fall) begin
        wr_flag <= addr_sh[6];
        addr_q  <= {addr_sh[5:0], mosi_bit};
      end
      if ((state_q == DATA) && sclk_fall && cs_low)
        data_sh <= {data_sh[DW-2:0], mosi_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      IDLE:   if (cs_low) state_d = ADDR;
      ADDR: begin
        if (cs_rise)             state_d = COMMIT;
        else if (addr_last_fall) state_d = DATA;
      end
      DATA:   if (cs_rise) state_d = COMMIT;
      COMMIT: begin
        state_d    = IDLE;
        // A zero count is a CS glitch; a full-length read or an
        // out-of-range address is accepted silently.
        commit_wr  = frame_full && wr_flag && addr_ok;
        commit_err = !frame_full && (bit_cnt != '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL;
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_stb    <= commit_wr;
      frame_err <= commit_err;
      if (commit_wr) begin
        reg_q[addr_q[IW-1:0]] <= data_sh;
        wr_addr               <= addr_q;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[g*DW +: DW] = reg_q[g];
  end

`ifdef SPI_REG_READBACK_EN
  logic          sclk_rise;
  logic [6:0]    rb_addr;
  logic [DW-1:0] rb_load;
  logic [DW-1:0] rb_sh;

  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  // The address is not latched yet on the 8th edge, so decode it from the
  // shifter plus the bit arriving now.
  assign rb_addr   = {addr_sh[5:0], mosi_bit};
  assign rb_load   = ({1'b0, rb_addr} < NREG_L) ? reg_q[rb_addr[IW-1:0]] : '0;

  // Each rising edge presents the current MSB on miso and shifts it out,
  // so the master sees data bit 1 on the first falling edge of the data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sh <= '0;
      miso  <= 1'b0;
    end else begin
      if (addr_last_fall)
        rb_sh <= rb_load;
      else if ((state_q == DATA) && sclk_rise)
        rb_sh <= {rb_sh[DW-2:0], 1'b0};
      if (state_q != DATA)
        miso <= 1'b0;
      else if (sclk_rise)
        miso <= rb_sh[DW-1];
    end
  end
`else
  assign miso = 1'b0;
`endif

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank. It is clocked entirely from the system clock, with SCLK, CS and MOSI oversampled through synchronisers. Each frame carries an address byte followed by a DW-bit data word, and either writes one of NREG registers or reads it back on MISO. It replaces the single 8-bit latch in the top level and drives the mux and peripheral select logic from a flat register bus.

## Interface
- `DW`, 8, data word width in bits; must be ≥ 2.
- `NREG`, 4, number of registers; valid range 1..128.
- `RESET_VAL`, 0, reset value loaded into every register (DW bits).
- `clk`  in  1  system clock (XTALCLK at top level).
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `cs`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, asynchronous.
- `miso`  out  1  SPI data out.
- `regs`  out  NREG*DW  flat register contents; register 0 sits in bits [DW-1:0].
- `wr_stb`  out  1  single-cycle pulse when a register is committed.
- `wr_addr`  out  7  address of the last committed write.
- `frame_err`  out  1  single-cycle pulse on a malformed frame.

## Operation
- Reset requirements:
  - One clock and one asynchronous active-low reset.
  - `rst_n` low forces state IDLE, every register to RESET_VAL, `wr_addr`=0, `wr_stb`=0, `frame_err`=0 and `miso`=0. This holds at any point in a frame, and the partial frame is discarded.
- Input synchronisation: `sclk`, `cs` and `mosi` each pass through a 2-flop synchroniser. A third flop on `sclk` and `cs` provides edge detection.
- SPI mode 1:
  - MOSI is sampled on each synchronised SCLK falling edge.
  - MISO is updated on each rising edge.
  - Bits arrive MSB first.
- Frame format: byte A is sent first, then D.
  - Byte A bit 7 = write flag (1 = write, 0 = read).
  - Byte A bits 6:0 = address.
  - D is DW bits of data.
- Bit counter behaviour:
  - Cleared whenever `cs` is high.
  - Increments on each sampled falling edge while `cs` is low.
  - Saturates at 8+DW+1, so overlong frames are detected and never alias to a valid length.
- FSM states:
  - IDLE: waiting for `cs` to fall; goes to ADDR.
  - ADDR: shifting the address byte. After 8 bits it latches flag and address, loads the readback shifter, and goes to DATA.
  - DATA: shifting data. Further bits beyond DW keep the counter saturated.
  - COMMIT: one cycle, entered from ADDR or DATA on the synchronised `cs` rising edge. Always returns to IDLE.
- Commit rules, evaluated in COMMIT:
  - Count = 8+DW, write flag = 1 and address < NREG: the register is updated, `wr_stb` pulses and `wr_addr` is updated.
  - Count = 8+DW with write flag = 0: valid read, nothing written, no error.
  - Count = 8+DW with address ≥ NREG: frame is silently dropped, no error.
  - Count = 0 (CS glitch): ignored, no error.
  - Any other count: `frame_err` pulses and nothing is written.
- A `cs` fall arriving while in COMMIT is acted on in IDLE the next cycle. No frame is lost, provided `cs` stays high for ≥ 3 `clk` cycles.

## Timing
- SCLK high time and low time must each be ≥ 4 `clk` periods. CS setup and hold around SCLK edges must be ≥ 4 `clk` periods.
- An input edge becomes visible to the FSM 3 `clk` cycles after the pin edge.
- `regs` and `wr_stb` change on the same `clk` edge: 4 cycles after the `cs` pin rises (3 cycles synchroniser/edge, plus 1 cycle COMMIT).
- `frame_err` follows the same latency as `wr_stb`.
- `miso` becomes valid ≤ 4 `clk` cycles after the SCLK pin edge that launches it.
- A new write to register N is visible in a read of N in the very next frame.

## Configuration
- `SPI_REG_READBACK_EN` defined:
  - On the 8th falling edge, the readback shifter loads the addressed register, or 0 if address ≥ NREG.
  - The shifter's MSB drives `miso` for data bit 1.
  - The shifter shifts on each subsequent rising edge.
  - `miso` is 0 outside the DATA state.
- `SPI_REG_READBACK_EN` undefined: the shifter is not built and `miso` is constantly 0. Reads are accepted but return zeros.

## Test plan
- Hold `rst_n` low, then release:
  - `regs` = all RESET_VAL, `miso`=0, no strobes.
- Defaults, write frame 0x82 / 0xA5:
  - Register 2 = 0xA5 and `regs[23:16]`=0xA5.
  - `wr_stb` pulses once, 4 cycles after the CS pin rises; `wr_addr`=2.
- Write 0x81/0x3C, then read 0x01/0x00 (readback enabled):
  - `miso` shifts out 0,0,1,1,1,1,0,0.
  - No `wr_stb` on the read.
- Frame of 15 bits, then a frame of 17 bits:
  - `frame_err` pulses each time and `regs` are unchanged.
- Write to address 0x7F with NREG=4:
  - No change, no `wr_stb`, no `frame_err`.
- Assert `rst_n` after the 12th bit of a write to register 1 = 0xFF:
  - Register 1 = RESET_VAL.
  - The next valid frame commits normally.
